apb_cmd_master: RTL
===================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data bus width (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum ACCESS cycles before abort (used only with timeout feature).
REQ-004 SHALL have port PCLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port PReset  input  1  reset, asynchronous assert, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command present.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr  input  ADDR_WIDTH  target byte address.
REQ-010 SHALL have port cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port cmd_wstrb  input  DATA_WIDTH/8  write byte strobes.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-014 SHALL have port rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-015 SHALL have port rsp_err  output  1  PSLVERR seen or timeout.
REQ-016 SHALL have ports PSELx, PENABLE, PWRITE  output  1 each  APB4 master controls.
REQ-017 SHALL have ports PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH; PWSTRB  output  DATA_WIDTH/8.
REQ-018 SHALL have ports PRDATA  input  DATA_WIDTH; PREADY  input  1; PSLVERR  input  1.

Function
REQ-019 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; cmd_ready high only in IDLE.
REQ-020 SHALL, on cmd_valid & cmd_ready, latch command and enter SETUP next cycle (PSELx=1, PENABLE=0).
REQ-021 SHALL enter ACCESS after exactly one SETUP cycle (PSELx=1, PENABLE=1), holding until PREADY=1.
REQ-022 SHALL hold PADDR, PWRITE, PWDATA, PWSTRB constant from SETUP through ACCESS completion.
REQ-023 SHALL drive PADDR with low log2(DATA_WIDTH/8) bits cleared; PWSTRB = 0 on reads.
REQ-024 SHALL, on ACCESS cycle with PREADY=1, register PRDATA (reads only) and PSLVERR into rsp_rdata/rsp_err, deassert PSELx/PENABLE, enter RESP.
REQ-025 SHALL hold rsp_valid and response data in RESP until rsp_ready=1, then return to IDLE next cycle.
REQ-026 SHALL give minimum latency of 3 cycles from accept edge to rsp_valid (zero-wait slave); minimum 4-cycle command-to-command spacing.
REQ-027 SHALL ignore PREADY, PSLVERR, PRDATA outside ACCESS.

Reset
REQ-028 SHALL, while PReset=1, force IDLE, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, PSELx=PENABLE=PWRITE=0, PADDR=PWDATA=PWSTRB=0; cmd_ready=1 first cycle after release.
REQ-029 SHALL, on reset mid-transfer, drop PSELx/PENABLE immediately and discard the command with no response.

Configuration
REQ-030 SHALL, with APB_CMD_MASTER_TIMEOUT_EN defined, count ACCESS cycles; after TIMEOUT_CYCLES without PREADY, deassert PSELx/PENABLE, enter RESP with rsp_err=1, rsp_rdata=0.
REQ-031 SHALL, without APB_CMD_MASTER_TIMEOUT_EN, wait in ACCESS indefinitely; no counter synthesized; TIMEOUT_CYCLES unused.

Structure
REQ-032 SHALL place FSM state enum and default width constants in shared package apb_cmd_master_pkg.
REQ-033 SHALL be a single module; no sub-module required.

Verification
REQ-034 Write addr 0x4, wdata 0x35, wstrb 0001, PREADY tied 1 -> one SETUP, one ACCESS cycle, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-035 Read addr 0x8, PREADY after 3 wait cycles, PRDATA=0x80 -> PENABLE high 4 cycles, PWSTRB=0, rsp_rdata=0x80.
REQ-036 Read addr 0xC with PSLVERR=1 at PREADY -> rsp_err=1, rsp_rdata=0; next command accepted normally.
REQ-037 TIMEOUT_CYCLES=16, PREADY held 0 -> with macro rsp_err=1 after 16 ACCESS cycles; without macro PENABLE still high after 100 cycles.
REQ-038 rsp_ready held 0 for 10 cycles, then PReset pulsed during a following ACCESS -> response held stable 10 cycles; reset drops PSELx at once, no rsp_valid afterward.

Source files
------------

// File: rtl/apb_cmd_master_pkg.sv
// Shared definitions for apb_cmd_master.
//   - Default width/timeout constants used as parameter defaults by the top.
//   - FSM state encoding (IDLE -> SETUP -> ACCESS -> RESP -> IDLE).
package apb_cmd_master_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH     = 32;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t ST_IDLE   = 2'd0;
    localparam apb_state_t ST_SETUP  = 2'd1;
    localparam apb_state_t ST_ACCESS = 2'd2;
    localparam apb_state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into single APB4 transfers
// and returns one response per command.
//
// Optional feature macro: APB_CMD_MASTER_TIMEOUT_EN
//   When defined, an ACCESS phase that sees no PREADY for TIMEOUT_CYCLES cycles is
//   aborted and answered with rsp_err=1, rsp_rdata=0. When undefined, ACCESS waits
//   indefinitely and no counter exists.
//
// Ports:
//   PCLK, PReset              clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_ready high only in IDLE
//   cmd_write/addr/wdata/wstrb command fields, latched on accept
//   rsp_valid/rsp_ready       response handshake; held in RESP until consumed
//   rsp_rdata, rsp_err        read data (0 for writes/errors), error flag
//   PSELx, PENABLE, PWRITE,
//   PADDR, PWDATA, PWSTRB     APB4 master outputs
//   PRDATA, PREADY, PSLVERR   APB4 slave inputs, only looked at in ACCESS
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    PCLK,
    input  logic                    PReset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    output logic                    PSELx,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PWSTRB,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
    // Clears the byte-lane bits so PADDR is always bus-word aligned.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

    if ((TIMEOUT_CYCLES == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_param_check
        $error("apb_cmd_master: TIMEOUT_CYCLES must be nonzero, DATA_WIDTH a multiple of 8");
    end

    apb_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pwstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic accept;
    logic done;
    logic timeout;

    // Gated by reset so the handshake is closed while reset is held.
    assign cmd_ready = (state_q == ST_IDLE) && !PReset;
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state_q == ST_ACCESS) && PREADY;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;

    // Counts completed ACCESS cycles; fires on the last allowed one.
    assign timeout = (state_q == ST_ACCESS) && !PREADY &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or posedge PReset) begin
        if (PReset) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_ACCESS) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (done || timeout) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PReset) begin
        if (PReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command fields are captured once on accept and stay put through ACCESS.
    always_ff @(posedge PCLK or posedge PReset) begin
        if (PReset) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pwstrb_q <= '0;
        end else if (accept) begin
            paddr_q  <= cmd_addr & ADDR_MASK;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_wdata;
            pwstrb_q <= cmd_write ? cmd_wstrb : '0;
        end
    end

    // Response is captured at the end of ACCESS and held through RESP.
    always_ff @(posedge PCLK or posedge PReset) begin
        if (PReset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (done) begin
            rdata_q <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
            err_q   <= PSLVERR;
        end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

    // Select/enable decode straight from the state so reset drops them at once.
    assign PSELx     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWSTRB    = pwstrb_q;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
